// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer and memory-port arbiter.
// After reset, the loader owns the single-port instruction memory.
// Once the loader marks its last word, the block streams sequential reads from pc
// to the decode stage. The stream uses a valid/ready handshake backed by a
// 2-entry response FIFO.
module insn_fetch_ctrl #(
  parameter int unsigned          ADDR_W   = 10,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn_out,
  output logic [ADDR_W-1:0] insn_pc,
  output logic [ADDR_W-1:0] pc_out,
  output logic              loading
);

  typedef enum logic {
    ST_LOAD  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               pending_q, pending_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [1:0]         occ_q, occ_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]  fifo_data_q [2];
  logic [DATA_W-1:0]  fifo_data_d [2];
  logic [ADDR_W-1:0]  fifo_pc_q [2];
  logic [ADDR_W-1:0]  fifo_pc_d [2];

  logic               pop;
  logic               push;
  logic               issue;
  logic [2:0]         fill_lvl;

  assign insn_valid = (occ_q != 2'd0);
  assign insn_out   = fifo_data_q[rd_ptr_q];
  assign insn_pc    = fifo_pc_q[rd_ptr_q];
  assign pc_out     = pc_q;

  // Handshake terms and projected FIFO fill used by the issue rule.
  always_comb begin
    pop      = insn_valid && insn_ready;
    push     = pending_q;
    fill_lvl = {1'b0, occ_q} + {2'b00, pending_q} - {2'b00, pop};
  end

  // Next-state, memory-port muxing and FIFO bookkeeping.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pending_d   = 1'b0;
    pend_pc_d   = pend_pc_q;
    occ_d       = occ_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    ld_ready    = 1'b0;
    loading     = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc_q;
    mem_wdata   = '0;
    issue       = 1'b0;

    unique case (state_q)
      ST_LOAD: begin
        ld_ready = 1'b1;
        loading  = 1'b1;
        if (ld_valid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = ld_addr;
          mem_wdata = ld_data;
          if (ld_last) begin
            state_d = ST_FETCH;
            pc_d    = RESET_PC;
          end
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          // Flush: drop buffered and in-flight responses and restart at the target.
          pc_d     = redirect_pc;
          occ_d    = 2'd0;
          rd_ptr_d = 1'b0;
          wr_ptr_d = 1'b0;
        end else begin
          issue = (fill_lvl <= 3'd1);
          if (push) begin
            fifo_data_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]   = pend_pc_q;
            wr_ptr_d              = ~wr_ptr_q;
          end
          if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
          end
          occ_d = occ_q + {1'b0, push} - {1'b0, pop};
          if (issue) begin
            mem_en    = 1'b1;
            mem_addr  = pc_q;
            pending_d = 1'b1;
            pend_pc_d = pc_q;
            pc_d      = pc_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    // The memory port stays idle while reset is asserted, regardless of loader inputs.
    if (!rst_n) begin
      mem_en = 1'b0;
      mem_we = 1'b0;
    end
  end

  // State, pc, in-flight tracking and response FIFO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      pend_pc_q <= '0;
      occ_q     <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      pend_pc_q <= pend_pc_d;
      occ_q     <= occ_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data_q[i] <= fifo_data_d[i];
        fifo_pc_q[i]   <= fifo_pc_d[i];
      end
    end
  end

endmodule

// File: doc/insn_fetch_ctrl.md
Name: insn_fetch_ctrl

Overview:
Fetch sequencer and port arbiter for the single-port synchronous instruction memory (32-bit x 1024).
- After reset, it grants the memory port to a program loader.
- Once loading completes, it streams sequential instruction reads from the PC to the decode stage through a valid/ready handshake.
- It supports PC redirect (branch/jump) and consumer backpressure without losing or duplicating instructions.

Parameters:
- ADDR_W, 10, memory index width (depth 2^ADDR_W).
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch index after load completes.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  loader write request.
- ld_ready  output  1  loader write accepted this cycle.
- ld_addr  input  ADDR_W  loader write index.
- ld_data  input  DATA_W  loader write instruction.
- ld_last  input  1  marks the final loader word.
- redirect_valid  input  1  PC redirect request.
- redirect_pc  input  ADDR_W  redirect target index.
- mem_en  output  1  memory access enable.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory index.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid the cycle after a read is issued.
- insn_valid  output  1  insn_out/insn_pc hold a valid instruction.
- insn_ready  input  1  consumer accepts the head instruction.
- insn_out  output  DATA_W  fetched instruction.
- insn_pc  output  ADDR_W  index the instruction was fetched from.
- pc_out  output  ADDR_W  next index to be issued.
- loading  output  1  high in LOAD state.

Behaviour:
Reset:
- rst_n low forces state=LOAD, pc=RESET_PC, pending=0, FIFO empty.
- insn_valid=0, insn_out=0, insn_pc=0.
- mem_en=0, mem_we=0 while rst_n low.
- Reset mid-load or mid-fetch drops all in-flight data. Memory contents are not touched.

States:
- LOAD:
  - ld_ready=1, loading=1.
  - ld_valid=1: mem_en=1, mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data, same cycle (combinational).
  - ld_valid&&ld_last moves to FETCH next cycle, with pc=RESET_PC.
  - redirect_valid and insn_ready are ignored.
- FETCH:
  - ld_ready=0, mem_we=0; loader requests are ignored.
  - There is no path back to LOAD except reset.

Issue (FETCH):
- issue = !redirect_valid && (occ + pending - pop <= 1).
  - occ is the response-FIFO occupancy (0..2).
  - pending=1 when a read was issued last cycle.
  - pop = insn_valid && insn_ready.
- On issue: mem_en=1, mem_addr=pc, issued index recorded, pc <= pc+1.
- pc wraps modulo 2^ADDR_W (1023 -> 0).
- pc_out = pc.

Response:
- The cycle after issue (pending=1), mem_rdata and the recorded index are pushed into a 2-entry FIFO.
- The FIFO head drives insn_out/insn_pc; insn_valid = occ != 0.
- Latency: issue at cycle t gives insn_valid at t+2.
- Steady state with insn_ready=1: one instruction per cycle.
- Push and pop in the same cycle are both honoured.
- The issue rule guarantees the FIFO never overflows.
- insn_out/insn_pc are stable while insn_valid && !insn_ready.

Redirect (FETCH only; highest priority):
- Effects, all in that same cycle:
  - pc <= redirect_pc.
  - FIFO flushed; insn_valid=0 next cycle.
  - Any pending response discarded, not pushed.
  - No issue.
  - A pop in that cycle is still considered consumed.
- Issue resumes at redirect_pc the following cycle; first valid two cycles after that.
- Back-to-back redirects: the last one wins.

Test Plan:
- Load: write 0x00208033@0, 0x002081B3@1, 0x00000013@2 (last), insn_ready=1 -> ld_ready=1 for 3 cycles, then loading=0. insn_valid rises 2 cycles after FETCH entry, then delivers in order with insn_pc 0,1,2.
- Backpressure: insn_ready=0 for 5 cycles mid-stream -> at most 2 buffered. Head held stable, mem_en drops. On release, consecutive insn_pc with no gaps or duplicates.
- Redirect: redirect_valid with redirect_pc=100 while fetching index 5 -> in-flight 4/5 discarded. Next delivered insn_pc=100 exactly 3 cycles after the redirect cycle, then 101.
- Wrap: redirect_pc=1022 -> delivered insn_pc 1022, 1023, 0, 1.
- Loader ignored: ld_valid=1 during FETCH -> mem_we stays 0, ld_ready=0.
- Reset mid-operation: rst_n low during streaming -> insn_valid=0 and mem_en=0 immediately (async). After release: LOAD state, pc=0, ld_ready=1.
